serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands DIGIT bits per clock, rippling the carry through a registered carry flop between slices. It is the sequential, width-generic successor to the team's single-bit full adder: each cycle evaluates a DIGIT-bit full-adder slice. It sits as a small arithmetic unit behind a start/busy/done handshake, so WIDTH can grow without growing the combinational carry chain beyond DIGIT bits.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; ≥1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH. N = WIDTH/DIGIT slice cycles.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when accepting (state IDLE or DONE).
- a  in  WIDTH  operand A; captured on accepting edge.
- b  in  WIDTH  operand B; captured on accepting edge.
- cin  in  1  carry-in for add mode; captured on accepting edge.
- sub  in  1  mode; 1 = subtract (A + ~B + 1, cin ignored); captured on accepting edge.
- sum  out  WIDTH  result; registered, updated only on completion.
- cout  out  1  carry out of bit WIDTH-1 (in sub mode: 1 = no borrow).
- overflow  out  1  signed two's-complement overflow of the completed operation.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → capture a, b_eff = sub ? ~b : b, carry = sub ? 1 : cin, slice index = 0; go RUN. start=0 → stay.
- RUN: each cycle compute slice i: {c, s} = a[i*DIGIT +: DIGIT] + b_eff[i*DIGIT +: DIGIT] + carry; write s into internal result register slice i; carry ← c; i ← i+1. start ignored. After slice N-1: sum ← full internal result, cout ← final carry, overflow ← (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]); go DONE.
- DONE: done=1 for this cycle only. start=1 → accept new operation exactly as in IDLE (back-to-back), go RUN; else go IDLE.
- sum/cout/overflow hold the last completed result through IDLE and through a subsequent RUN until the next completion.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Changes on a, b, cin, sub after the accepting edge have no effect on the operation in flight.

## Timing
- Reset (any state, including mid-RUN): state IDLE, sum=0, cout=0, overflow=0, busy=0, done=0, internal carry/index cleared; an aborted operation produces no done and does not touch sum.
- reset has priority over start on the same edge.
- Latency: start accepted at edge E0 → busy high from E0 to E(N); results and done visible after edge EN, i.e. N cycles after acceptance; done low again after E(N+1).
- Throughput: one result per N+1 cycles with start held high (accept in DONE); start held high does not cause re-acceptance during RUN.
- WIDTH=DIGIT (N=1): RUN lasts exactly one cycle; latency 1.
- busy and done never high in the same cycle.

## Test plan
- WIDTH=1, DIGIT=1, sub=0: all 8 (cin,a,b) combos, one start each → {cout,sum} equals cin+a+b (e.g. 1,1,1 → cout=1,sum=1; 1,0,1 → cout=1,sum=0); done exactly 1 cycle after each accept.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0, done 8 cycles after accept; a=0x7F, b=0x01 → sum=0x80, overflow=1, cout=0.
- WIDTH=8, DIGIT=4, sub=1: a=0x05, b=0x07 → sum=0xFE, cout=0, overflow=0, latency 2; a=0x80, b=0x01 → sum=0x7F, overflow=1, cout=1.
- Back-to-back, DIGIT=2: start held high, operands changed every cycle → each result matches operands present at its accepting edge; done pulses every 5 cycles; mid-RUN operand changes ignored.
- Reset mid-operation (WIDTH=8, DIGIT=1): accept 0x10+0x20, assert reset at cycle 3 → no done, sum=0, busy=0; next start 0x10+0x20 → sum=0x30 after 8 cycles.
- start and reset on the same edge → remain IDLE, busy=0; prior sum cleared to 0.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that processes DIGIT bits per
// clock. A registered carry flop links consecutive slices, so the longest
// combinational carry chain is DIGIT bits no matter how wide WIDTH grows.
// Handshake: start is accepted in IDLE or DONE, busy is high during RUN,
// and done pulses for one cycle when a result lands in sum/cout/overflow.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  // Number of slice cycles and width of the slice index (kept >= 1 bit).
  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;        // already inverted for subtraction
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IW-1:0]    idx_reg;

  logic [DIGIT-1:0] a_sl [N];
  logic [DIGIT-1:0] b_sl [N];
  logic [DIGIT-1:0] a_slice;
  logic [DIGIT-1:0] b_slice;
  logic [DIGIT-1:0] s_slice;
  logic             c_slice;
  logic             running;
  logic             last_slice;
  logic             ovf_next;

  assign running    = (state_reg == RUN);
  assign last_slice = running && (idx_reg == LAST_IDX);

  // Split the captured operands into slices and merge the freshly computed
  // slice into the partial result at the current index.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_sl[gi] = a_reg[gi*DIGIT +: DIGIT];
      assign b_sl[gi] = b_reg[gi*DIGIT +: DIGIT];
      assign result_next[gi*DIGIT +: DIGIT] =
        (running && (idx_reg == IW'(gi))) ? s_slice
                                          : result_reg[gi*DIGIT +: DIGIT];
    end
  endgenerate

  // One DIGIT-bit full-adder slice fed by the registered carry.
  always_comb begin
    a_slice = a_sl[idx_reg];
    b_slice = b_sl[idx_reg];
    {c_slice, s_slice} = {1'b0, a_slice} + {1'b0, b_slice}
                       + {{DIGIT{1'b0}}, carry_reg};
  end

  // Signed overflow: operands agree in sign but the result does not.
  assign ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (result_next[WIDTH-1] != a_reg[WIDTH-1]);

  // Control FSM, operand capture and result publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      sum_reg    <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      idx_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            idx_reg   <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          result_reg <= result_next;
          carry_reg  <= c_slice;
          if (last_slice) begin
            sum_reg   <= result_next;
            cout_reg  <= c_slice;
            ovf_reg   <= ovf_next;
            idx_reg   <= '0;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;
  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: drives four serial_adder configurations (1/1, 8/1, 8/4,
// 8/2) and checks every result against an arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start [4];
  logic [7:0] a     [4];
  logic [7:0] b     [4];
  logic       cin   [4];
  logic       sub   [4];
  logic       sum0;
  logic [7:0] sum1, sum2, sum3;
  logic       cout  [4];
  logic       ovf   [4];
  logic       busy  [4];
  logic       done  [4];

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(1), .DIGIT(1)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .a(a[0][0]), .b(b[0][0]),
    .cin(cin[0]), .sub(sub[0]), .sum(sum0), .cout(cout[0]),
    .overflow(ovf[0]), .busy(busy[0]), .done(done[0]));

  serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .a(a[1]), .b(b[1]),
    .cin(cin[1]), .sub(sub[1]), .sum(sum1), .cout(cout[1]),
    .overflow(ovf[1]), .busy(busy[1]), .done(done[1]));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .a(a[2]), .b(b[2]),
    .cin(cin[2]), .sub(sub[2]), .sum(sum2), .cout(cout[2]),
    .overflow(ovf[2]), .busy(busy[2]), .done(done[2]));

  serial_adder #(.WIDTH(8), .DIGIT(2)) u3 (
    .clk(clk), .reset(reset), .start(start[3]), .a(a[3]), .b(b[3]),
    .cin(cin[3]), .sub(sub[3]), .sum(sum3), .cout(cout[3]),
    .overflow(ovf[3]), .busy(busy[3]), .done(done[3]));

  function automatic logic [7:0] get_sum(input int k);
    case (k)
      0:       get_sum = {7'b0, sum0};
      1:       get_sum = sum1;
      2:       get_sum = sum2;
      default: get_sum = sum3;
    endcase
  endfunction

  function automatic int width_of(input int k);
    width_of = (k == 0) ? 1 : 8;
  endfunction

  function automatic int slices_of(input int k);
    case (k)
      0:       slices_of = 1;
      1:       slices_of = 8;
      2:       slices_of = 2;
      default: slices_of = 4;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input int w, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic sv,
                       output logic [7:0] es, output logic ec, output logic eo);
    int m, ai, bi, sa, sb, r, sr;
    m  = 1 << w;
    ai = int'(av) & (m - 1);
    bi = int'(bv) & (m - 1);
    sa = (ai >= m / 2) ? ai - m : ai;
    sb = (bi >= m / 2) ? bi - m : bi;
    if (sv) begin
      r  = ai - bi;
      sr = sa - sb;
      ec = (ai >= bi);
    end else begin
      r  = ai + bi + int'(cv);
      sr = sa + sb + int'(cv);
      ec = (r >= m);
    end
    es = 8'(((r % m) + m) % m);
    eo = (sr < -(m / 2)) || (sr > (m / 2 - 1));
  endtask

  // One accepted operation; operands are scrambled while it runs.
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic sv);
    logic [7:0] es;
    logic       ec, eo;
    int         lat, n;
    n = slices_of(k);
    model(width_of(k), av, bv, cv, sv, es, ec, eo);
    @(negedge clk);
    a[k] = av; b[k] = bv; cin[k] = cv; sub[k] = sv; start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    check("busy_after_accept", 32'(busy[k]), 32'd1);
    lat = 0;
    while (done[k] !== 1'b1 && lat < n + 4) begin
      a[k] = 8'($urandom); b[k] = 8'($urandom);
      cin[k] = 1'($urandom); sub[k] = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(n));
    check("sum", 32'(get_sum(k)), 32'(es));
    check("cout", 32'(cout[k]), 32'(ec));
    check("overflow", 32'(ovf[k]), 32'(eo));
    check("busy_with_done", 32'(busy[k]), 32'd0);
    $display("op inst=%0d a=%0h b=%0h cin=%0d sub=%0d -> sum=%0h cout=%0d ovf=%0d lat=%0d",
             k, av, bv, cv, sv, get_sum(k), cout[k], ovf[k], lat);
    @(negedge clk);
    check("done_one_cycle", 32'(done[k]), 32'd0);
  endtask

  logic [7:0] qa [0:20];
  logic [7:0] qb [0:20];
  logic       qc [0:20];
  logic       qs [0:20];

  initial begin
    logic [7:0] es;
    logic       ec, eo, seen;
    int         p;

    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start[k] = 1'b0; a[k] = '0; b[k] = '0; cin[k] = 1'b0; sub[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_sum", 32'(get_sum(k)), 32'd0);
      check("rst_cout", 32'(cout[k]), 32'd0);
      check("rst_ovf", 32'(ovf[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_done", 32'(done[k]), 32'd0);
    end
    reset = 1'b0;

    // 1-bit full adder: all cin/a/b combinations.
    for (int i = 0; i < 8; i++)
      run_op(0, {7'b0, i[1]}, {7'b0, i[0]}, i[2], 1'b0);

    // Directed boundary cases.
    run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(2, 8'h05, 8'h07, 1'b0, 1'b1);
    run_op(2, 8'h80, 8'h01, 1'b1, 1'b1);
    run_op(3, 8'h80, 8'h80, 1'b0, 1'b0);

    // Random operations on the 8-bit configurations.
    for (int i = 0; i < 6; i++)
      for (int k = 1; k < 4; k++)
        run_op(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    // Back-to-back with start held high, operands changing every cycle.
    @(negedge clk);
    start[3] = 1'b1;
    qa[0] = 8'($urandom); qb[0] = 8'($urandom);
    qc[0] = 1'($urandom); qs[0] = 1'($urandom);
    a[3] = qa[0]; b[3] = qb[0]; cin[3] = qc[0]; sub[3] = qs[0];
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      p = j % 5;
      check("b2b_busy", 32'(busy[3]), 32'(p < 4));
      check("b2b_done", 32'(done[3]), 32'(p == 4));
      if (p == 4) begin
        model(8, qa[j-4], qb[j-4], qc[j-4], qs[j-4], es, ec, eo);
        check("b2b_sum", 32'(sum3), 32'(es));
        check("b2b_cout", 32'(cout[3]), 32'(ec));
        check("b2b_ovf", 32'(ovf[3]), 32'(eo));
        $display("b2b edge=%0d a=%0h b=%0h cin=%0d sub=%0d -> sum=%0h",
                 j, qa[j-4], qb[j-4], qc[j-4], qs[j-4], sum3);
      end
      qa[j+1] = 8'($urandom); qb[j+1] = 8'($urandom);
      qc[j+1] = 1'($urandom); qs[j+1] = 1'($urandom);
      a[3] = qa[j+1]; b[3] = qb[j+1]; cin[3] = qc[j+1]; sub[3] = qs[j+1];
      if (j == 19) start[3] = 1'b0;
    end
    @(negedge clk);
    check("b2b_end_busy", 32'(busy[3]), 32'd0);
    check("b2b_end_done", 32'(done[3]), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a[1] = 8'h10; b[1] = 8'h20; cin[1] = 1'b0; sub[1] = 1'b0; start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy[1]), 32'd0);
    check("abort_sum", 32'(sum1), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | done[1];
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen), 32'd0);
    $display("abort: reset mid-run, sum=%0h busy=%0d", sum1, busy[1]);
    run_op(1, 8'h10, 8'h20, 1'b0, 1'b0);

    // start and reset on the same edge.
    @(negedge clk);
    a[1] = 8'h05; b[1] = 8'h06; start[1] = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start[1] = 1'b0;
    check("same_edge_busy", 32'(busy[1]), 32'd0);
    check("same_edge_sum", 32'(sum1), 32'd0);
    @(negedge clk);
    check("same_edge_busy2", 32'(busy[1]), 32'd0);
    check("same_edge_done", 32'(done[1]), 32'd0);
    $display("same-edge: reset wins, sum=%0h busy=%0d", sum1, busy[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
